// File: rtl/fifo_read_ctrl.sv
// fifo_read_ctrl: read-domain drain controller for the dual-clock FIFO.
// Pops full bursts (or timed-out partial fills) into a 2-entry skid buffer feeding a valid/ready stream.
module fifo_read_ctrl #(
  parameter int DATA_WIDTH = 8,
  parameter int ADD_WIDTH  = 5,
  parameter int BURST_LEN  = 4,
  parameter int TIMEOUT    = 16
) (
  input  logic                  clk_read,
  input  logic                  a_Reset,
  input  logic [ADD_WIDTH:0]    fifo_level,
  output logic                  Read_enable,
  input  logic [DATA_WIDTH-1:0] fifo_data,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  m_valid,
  output logic                  m_last,
  input  logic                  m_ready,
  output logic                  busy,
  output logic [15:0]           burst_count
);

  localparam int LW = ADD_WIDTH + 1;
  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [LW-1:0] BURST = LW'(BURST_LEN);
  localparam logic [TW-1:0] TLAST = TW'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, READ, DRAIN} state_t;

  state_t                state;
  logic [TW-1:0]         tcnt;
  logic [LW-1:0]         remaining;
  logic [1:0]            occ;
  logic                  inflight;
  logic                  inflight_last;
  logic [DATA_WIDTH-1:0] tail_data;
  logic                  tail_last;
  logic                  pop;
  logic                  push;
  logic [2:0]            pending;

  assign pop     = m_valid & m_ready;
  assign push    = inflight;
  assign pending = {1'b0, occ} + {2'b00, inflight};
  assign m_valid = (occ != 2'd0);

  // A read is allowed only if its word is guaranteed a free buffer slot two cycles later.
  always_comb begin
    Read_enable = 1'b0;
    if (!a_Reset && state == READ && remaining != '0)
      Read_enable = (pending < (3'd2 + {2'b00, pop}));
  end

  always_ff @(posedge clk_read) begin
    if (a_Reset) begin
      state     <= IDLE;
      tcnt      <= '0;
      remaining <= '0;
      busy      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (fifo_level >= BURST) begin
            state     <= READ;
            remaining <= BURST;
            tcnt      <= '0;
            busy      <= 1'b1;
          end else if (fifo_level != '0 && tcnt == TLAST) begin
            state     <= READ;
            remaining <= fifo_level;
            tcnt      <= '0;
            busy      <= 1'b1;
          end else if (fifo_level != '0) begin
            tcnt <= tcnt + TW'(1);
          end else begin
            tcnt <= '0;
          end
        end
        READ: begin
          if (Read_enable)
            remaining <= remaining - LW'(1);
          if (remaining == '0 || (Read_enable && remaining == LW'(1)))
            state <= DRAIN;
        end
        DRAIN: begin
          if (!inflight && occ == 2'd0) begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk_read) begin
    if (a_Reset) begin
      inflight      <= 1'b0;
      inflight_last <= 1'b0;
    end else begin
      inflight      <= Read_enable;
      inflight_last <= Read_enable && (remaining == LW'(1));
    end
  end

  // Head entry drives m_data/m_last directly; the tail only fills while the head is stalled.
  always_ff @(posedge clk_read) begin
    if (a_Reset) begin
      occ         <= 2'd0;
      m_data      <= '0;
      m_last      <= 1'b0;
      tail_data   <= '0;
      tail_last   <= 1'b0;
      burst_count <= 16'd0;
    end else begin
      if (pop && m_last)
        burst_count <= burst_count + 16'd1;
      case (occ)
        2'd0: begin
          if (push) begin
            m_data <= fifo_data;
            m_last <= inflight_last;
            occ    <= 2'd1;
          end
        end
        2'd1: begin
          if (push && pop) begin
            m_data <= fifo_data;
            m_last <= inflight_last;
          end else if (push) begin
            tail_data <= fifo_data;
            tail_last <= inflight_last;
            occ       <= 2'd2;
          end else if (pop) begin
            m_last <= 1'b0;
            occ    <= 2'd0;
          end
        end
        default: begin
          if (pop) begin
            m_data <= tail_data;
            m_last <= tail_last;
            if (push) begin
              tail_data <= fifo_data;
              tail_last <= inflight_last;
            end else begin
              occ <= 2'd1;
            end
          end
        end
      endcase
    end
  end

  assert property (@(posedge clk_read) disable iff (a_Reset) occ != 2'd3);
  assert property (@(posedge clk_read) disable iff (a_Reset) !(push && !pop && occ == 2'd2));
  assert property (@(posedge clk_read) disable iff (a_Reset) m_last |-> m_valid);

endmodule
